// File: rtl/jk_updown_counter.sv
// jk_updown_counter
//   Synchronous modulo-MODULO up/down counter built from a bank of JK flops.
//   Count steps use T-to-JK excitation (J=K=T); load and wrap use direct
//   set/clear excitation (J=d, K=~d).
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   en       count enable
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous parallel load (wins over en)
//   load_val value to load, clamped to MODULO-1
//   Q        counter state, one JK flop per bit
//   Q_bar    complement of Q, from each flop's Q_bar
//   tc       terminal count, combinational
//   wrap     registered one-cycle pulse, high while Q shows the post-wrap value

// jk_ff
//   JK flip-flop with synchronous active-high reset to 0.
//   JK: 00 hold, 01 clear, 10 set, 11 toggle.
// Ports: clk, rst, J, K inputs; Q, Q_bar outputs.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_bar
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({J, K})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;

endmodule

module jk_updown_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic             at_max;
  logic             at_zero;
  logic             wrap_d;
  logic             wrap_q;

  // Zero-extend before comparing so MODULO = 2^WIDTH is handled correctly.
  assign load_d  = (32'(load_val) >= 32'(MODULO)) ? MAX_VAL : load_val;
  assign at_max  = (Q == MAX_VAL);
  assign at_zero = (Q == '0);

  // Toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & Q[i-1];
      t_dn[i] = t_dn[i-1] & Q_bar[i-1];
    end
  end

  // Excitation; reset is applied inside each flop and overrides all of this.
  always_comb begin
    j      = '0;
    k      = '0;
    wrap_d = 1'b0;
    if (load) begin
      j = load_d;
      k = ~load_d;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          j      = '0;
          k      = '1;
          wrap_d = 1'b1;
        end else begin
          j = t_up;
          k = t_up;
        end
      end else begin
        if (at_zero) begin
          j      = MAX_VAL;
          k      = ~MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          j = t_dn;
          k = t_dn;
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff u_jk (
      .clk   (clk),
      .rst   (rst),
      .J     (j[g]),
      .K     (k[g]),
      .Q     (Q[g]),
      .Q_bar (Q_bar[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
  assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Synchronous modulo-N up/down counter built structurally from a bank of JK flip-flops.
- Each bit's JK inputs come from excitation logic:
  - count mode uses the T-to-JK conversion J=K=T;
  - load and wrap use direct set/clear excitation.
- Used as the general counter primitive beside the T-based flop library, and as the structural check of the JK cell.

Parameters:
- WIDTH, 4, counter and JK bank width in bits.
- MODULO, 16, count range 0..MODULO-1. Legal range 2..2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- Q  output  WIDTH  counter state; each bit is the Q of its JK flop.
- Q_bar  output  WIDTH  bitwise complement of Q, taken from each flop's Q_bar.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse marking a wrap.

Behaviour:
- Internal cell jk_ff (clk, rst, J, K, Q, Q_bar): synchronous active-high reset to 0.
  - JK=00 holds; 01 clears; 10 sets; 11 toggles.
  - Q_bar = ~Q continuously.
- Priority per edge: rst > load > en > hold.
- Reset: Q=0, Q_bar=all ones, wrap=0. Reset mid-count or mid-load wins unconditionally on that edge.
- Load (load=1): bit i gets J=d_i, K=~d_i, where d = load_val.
  - If load_val >= MODULO, d = MODULO-1 (clamp).
  - wrap=0 on a load edge. Latency 1 cycle. en and up are ignored.
- Count up (en=1, up=1, load=0):
  - Q != MODULO-1: T_0=1, T_i = &Q[i-1:0], J_i=K_i=T_i.
  - Q == MODULO-1: all bits J=0, K=1, so Q becomes 0; wrap=1 on the following cycle.
- Count down (en=1, up=0, load=0):
  - Q != 0: T_0=1, T_i = &Q_bar[i-1:0], J_i=K_i=T_i.
  - Q == 0: load-style excitation to MODULO-1; wrap=1 on the following cycle.
- Hold (en=0, load=0): all J=K=0; wrap=0.
- wrap is a register. It is high exactly in the cycle in which Q shows the post-wrap value, and otherwise 0.
- tc = en & ((up & Q==MODULO-1) | (~up & Q==0)). Purely combinational, no reset dependency beyond Q.
- Direction change mid-count takes effect on the next edge. No extra latency, no glitch on Q.
- MODULO = 2^WIDTH: the wrap path gives the same result as natural toggle overflow. The explicit excitation is still used.
- Q is never outside 0..MODULO-1 after any sequence of inputs.

Test Plan:
- Reset: WIDTH=4, MODULO=16; rst=1 for 2 cycles with en=1, load=1, load_val=9 -> Q=0, Q_bar=4'hF, wrap=0.
- Up wrap: WIDTH=4, MODULO=10; en=1, up=1 from 0 for 11 edges -> Q goes 0..9 then 0, then 1.
  - tc=1 only while Q=9.
  - wrap=1 only in the cycle Q first returns to 0.
- Down wrap: WIDTH=4, MODULO=10; start at 2, en=1, up=0, 4 edges -> Q goes 1, 0, 9, 8.
  - tc=1 at Q=0.
  - wrap=1 in the cycle Q=9.
- Load and clamp: WIDTH=4, MODULO=10.
  - load=1 with load_val=6 -> Q=6 next cycle.
  - load_val=13 -> Q=9.
  - load together with en=1, up=1 at Q=9 -> load wins, wrap=0.
- Hold and direction flip: WIDTH=4, MODULO=16 at Q=5.
  - en=0 for 3 cycles -> Q stays 5.
  - Then en=1 with up alternating 1, 0, 1 -> Q goes 6, 5, 6.
- Reset priority mid-wrap: WIDTH=4, MODULO=16 at Q=15 with en=1, up=1; assert rst on that edge -> Q=0, wrap=0 the next cycle (no wrap pulse).
